// File: rtl/l2_feature_stream_seq.sv
// rtl/l2_feature_stream_seq.sv - credit-gated raster sequencer feeding the layer-2 line-buffer bank
module l2_feature_stream_seq #(
  parameter int F     = 14,
  parameter int B     = 8,
  parameter int ICH   = 16,
  parameter int KY    = 3,
  parameter int LINES = 4,
  localparam int AW   = $clog2(F*F),
  localparam int RW   = $clog2(F),
  localparam int CW   = $clog2(LINES+1),
  localparam int IW   = $clog2(F+1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_rd_en,
  output logic [AW-1:0]        o_rd_addr,
  input  logic [ICH*B-1:0]     i_rd_data,
  output logic [ICH*B-1:0]     o_pixel_data,
  output logic [ICH-1:0]       o_pixel_data_valid,
  input  logic [ICH-1:0]       i_intr,
  output logic                 o_err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [RW-1:0]      row_q, row_d, col_q, col_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [CW-1:0]      credit_q, credit_d;
  logic [IW-1:0]      intr_cnt_q, intr_cnt_d;
  logic               rd_en_d1_q, rd_en_d1_d;
  logic [ICH*B-1:0]   pix_q, pix_d;
  logic [ICH-1:0]     vld_q, vld_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic               rd_en, charge, intr_all, intr_ev;

  // Read strobe follows the state directly so a row is charged in the cycle its last read is on the bus.
  assign rd_en    = (state_q == S_LOAD) && (credit_q != '0);
  assign charge   = rd_en && (col_q == RW'(F-1));
  assign intr_all = &i_intr;
  assign intr_ev  = intr_all && (state_q != S_IDLE);

  // Next-state: credits, raster counters, data pipeline and FSM transitions.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    addr_d     = addr_q;
    credit_d   = credit_q;
    intr_cnt_d = intr_cnt_q;
    err_d      = err_q;
    rd_en_d1_d = rd_en;
    pix_d      = rd_en_d1_q ? i_rd_data : pix_q;
    vld_d      = {ICH{rd_en_d1_q}};

    // Disagreeing interrupt bits mean the bank lost lockstep; the cycle carries no credit.
    if ((|i_intr) && !intr_all) err_d = 1'b1;

    if (charge && !intr_ev) begin
      credit_d = credit_q - CW'(1);
    end else if (intr_ev && !charge) begin
      if (credit_q == CW'(LINES)) err_d = 1'b1;
      else                        credit_d = credit_q + CW'(1);
    end
    if (intr_ev) intr_cnt_d = intr_cnt_q + IW'(1);

    if (rd_en) begin
      addr_d = addr_q + AW'(1);
      if (col_q == RW'(F-1)) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + RW'(1);
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (i_start) begin
          state_d    = S_LOAD;
          row_d      = '0;
          col_d      = '0;
          addr_d     = '0;
          intr_cnt_d = '0;
          credit_d   = CW'(LINES);
        end
      end
      S_LOAD: begin
        if (charge) begin
          if (row_q == RW'(F-1))  state_d = S_DRAIN;
          else if (credit_d == '0) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (credit_q != '0) state_d = S_LOAD;
      end
      S_DRAIN: begin
        if ((intr_cnt_q == IW'(F-KY+1)) && !rd_en_d1_q && !vld_q[0]) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_LOAD) || (state_d == S_WAIT) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs; reset abandons any map in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      addr_q     <= '0;
      credit_q   <= CW'(LINES);
      intr_cnt_q <= '0;
      rd_en_d1_q <= 1'b0;
      pix_q      <= '0;
      vld_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      addr_q     <= addr_d;
      credit_q   <= credit_d;
      intr_cnt_q <= intr_cnt_d;
      rd_en_d1_q <= rd_en_d1_d;
      pix_q      <= pix_d;
      vld_q      <= vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign o_busy             = busy_q;
  assign o_done             = done_q;
  assign o_rd_en            = rd_en;
  assign o_rd_addr          = addr_q;
  assign o_pixel_data       = pix_q;
  assign o_pixel_data_valid = vld_q;
  assign o_err              = err_q;

endmodule

// File: tb/tb_l2_feature_stream_seq.sv
// tb/tb_l2_feature_stream_seq.sv - directed bench for the layer-2 feature stream sequencer
module tb_l2_feature_stream_seq;
  localparam int F = 14, B = 8, ICH = 16, KY = 3, LINES = 4, AW = 8;

  logic               i_clk = 1'b0, i_rst = 1'b1, i_start = 1'b0;
  logic [ICH*B-1:0]   i_rd_data = '0;
  logic [ICH-1:0]     i_intr, man_intr = '0, auto_intr = '0;
  logic               o_busy, o_done, o_rd_en, o_err;
  logic [AW-1:0]      o_rd_addr;
  logic [ICH*B-1:0]   o_pixel_data;
  logic [ICH-1:0]     o_pixel_data_valid;

  int n_asrt = 0, n_fail = 0;
  int rd_cnt, exp_addr, addr_bad, vld_cnt, lat_bad, data_bad, done_cnt, done_ev, done_busy, auto_ev;
  int clr_req = 0, clr_seen = 0;
  logic bank_auto = 1'b0;
  logic h1, h2;
  logic [AW-1:0] a1, a2;

  assign i_intr = man_intr | auto_intr;
  always #5 i_clk = ~i_clk;

  l2_feature_stream_seq #(.F(F), .B(B), .ICH(ICH), .KY(KY), .LINES(LINES)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_pixel_data(o_pixel_data), .o_pixel_data_valid(o_pixel_data_valid),
    .i_intr(i_intr), .o_err(o_err)
  );

  function automatic logic [ICH*B-1:0] pat(input logic [AW-1:0] a);
    logic [ICH*B-1:0] r;
    for (int c = 0; c < ICH; c++) r[c*B +: B] = a + 8'(c*16);
    return r;
  endfunction

  // Feature RAM: data one cycle after the read strobe.
  always @(posedge i_clk) if (o_rd_en) i_rd_data <= pat(o_rd_addr);

  // Monitor and bank model: read order, strobe latency, data, done, auto interrupts.
  always @(negedge i_clk) begin
    if (clr_req != clr_seen) begin
      clr_seen = clr_req;
      rd_cnt = 0; exp_addr = 0; addr_bad = 0; vld_cnt = 0; lat_bad = 0; data_bad = 0;
      done_cnt = 0; done_ev = 0; done_busy = 0; auto_ev = 0; h1 = 1'b0; h2 = 1'b0; a1 = '0; a2 = '0;
    end
    auto_intr = '0;
    if (o_rd_en) begin
      if (o_rd_addr !== AW'(exp_addr)) addr_bad++;
      exp_addr++;
      rd_cnt++;
    end
    if (o_pixel_data_valid !== {ICH{h2}}) lat_bad++;
    if (o_pixel_data_valid[0]) begin
      vld_cnt++;
      if (o_pixel_data !== pat(a2)) data_bad++;
      if (bank_auto && (vld_cnt % F == 0) && (vld_cnt / F >= KY)) begin
        auto_intr = '1;
        auto_ev++;
      end
    end
    if (o_done) begin
      done_cnt++;
      done_ev = auto_ev;
      done_busy = int'(o_busy);
    end
    h2 = h1; h1 = o_rd_en; a2 = a1; a1 = o_rd_addr;
  end

  task automatic step(input int n);
    repeat (n) @(negedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_pulse();
    i_start = 1'b1; step(1); i_start = 1'b0;
  endtask

  task automatic pulse_intr(input logic [ICH-1:0] v);
    man_intr = v; step(1); man_intr = '0;
  endtask

  initial begin
    // Reset state
    step(3);
    chk("rst_busy", 128'(o_busy), 128'(0));
    chk("rst_done", 128'(o_done), 128'(0));
    chk("rst_rd_en", 128'(o_rd_en), 128'(0));
    chk("rst_addr", 128'(o_rd_addr), 128'(0));
    chk("rst_valid", 128'(o_pixel_data_valid), 128'(0));
    chk("rst_data", 128'(o_pixel_data), 128'(0));
    chk("rst_err", 128'(o_err), 128'(0));
    i_rst = 1'b0; clr_req++;
    step(2);

    // Reset in the middle of LOAD at row 2, col 5
    start_pulse();
    for (int k = 0; k < 100 && !(o_rd_en && o_rd_addr == 8'd33); k++) step(1);
    chk("t1_reach_addr33", 128'(o_rd_en && o_rd_addr == 8'd33), 128'(1));
    i_rst = 1'b1; clr_req++;
    step(1);
    chk("t1_busy", 128'(o_busy), 128'(0));
    chk("t1_rd_en", 128'(o_rd_en), 128'(0));
    chk("t1_addr", 128'(o_rd_addr), 128'(0));
    chk("t1_valid", 128'(o_pixel_data_valid), 128'(0));
    chk("t1_data", 128'(o_pixel_data), 128'(0));
    step(1); i_rst = 1'b0; step(1);

    // Restart with no interrupts: four rows then stall
    start_pulse();
    step(200);
    chk("t2_reads", 128'(rd_cnt), 128'(56));
    chk("t2_addr_order", 128'(addr_bad), 128'(0));
    chk("t2_rd_en_idle", 128'(o_rd_en), 128'(0));
    chk("t2_busy", 128'(o_busy), 128'(1));
    chk("t2_strobes", 128'(vld_cnt), 128'(56));
    chk("t2_latency", 128'(lat_bad), 128'(0));
    chk("t2_data", 128'(data_bad), 128'(0));
    chk("t2_hold", 128'(o_pixel_data), 128'(pat(8'd55)));

    // One credit returned: exactly one more row
    pulse_intr('1);
    step(60);
    chk("t3_reads", 128'(rd_cnt), 128'(70));
    chk("t3_addr_order", 128'(addr_bad), 128'(0));
    chk("t3_rd_en_idle", 128'(o_rd_en), 128'(0));

    // Credit return coincides with the row charge on address 83
    pulse_intr('1);
    for (int k = 0; k < 60 && !(o_rd_en && o_rd_addr == 8'd83); k++) step(1);
    chk("t5_reach_addr83", 128'(o_rd_en && o_rd_addr == 8'd83), 128'(1));
    man_intr = '1; step(1); man_intr = '0;
    chk("t5_no_stall_en", 128'(o_rd_en), 128'(1));
    chk("t5_no_stall_addr", 128'(o_rd_addr), 128'(84));
    step(60);
    chk("t5_reads", 128'(rd_cnt), 128'(98));
    chk("t5_rd_en_idle", 128'(o_rd_en), 128'(0));

    // Partial interrupt: sticky error, no credit, no count; start while busy ignored
    pulse_intr(16'h0001);
    step(2);
    chk("t6_err", 128'(o_err), 128'(1));
    start_pulse();
    step(40);
    chk("t6_reads", 128'(rd_cnt), 128'(98));
    chk("t6_busy", 128'(o_busy), 128'(1));
    chk("t6_addr_order", 128'(addr_bad), 128'(0));
    repeat (7) begin
      pulse_intr('1);
      step(30);
    end
    chk("t6_all_read", 128'(rd_cnt), 128'(196));
    pulse_intr('1);
    step(10);
    chk("t6_no_done_11", 128'(done_cnt), 128'(0));
    pulse_intr('1);
    step(10);
    chk("t6_done_12", 128'(done_cnt), 128'(1));
    chk("t6_done_busy", 128'(done_busy), 128'(0));
    chk("t6_err_sticky", 128'(o_err), 128'(1));
    chk("t6_addr_order_end", 128'(addr_bad), 128'(0));
    chk("t6_data", 128'(data_bad), 128'(0));

    // Full map with the bank returning credits after each row beyond KY-1
    i_rst = 1'b1; clr_req++;
    step(2);
    chk("t4_err_cleared", 128'(o_err), 128'(0));
    i_rst = 1'b0; bank_auto = 1'b1;
    step(1);
    start_pulse();
    for (int k = 0; k < 3000 && done_cnt == 0; k++) step(1);
    step(5);
    chk("t4_done_once", 128'(done_cnt), 128'(1));
    chk("t4_done_after_12", 128'(done_ev), 128'(12));
    chk("t4_busy_at_done", 128'(done_busy), 128'(0));
    chk("t4_reads", 128'(rd_cnt), 128'(196));
    chk("t4_addr_order", 128'(addr_bad), 128'(0));
    chk("t4_strobes", 128'(vld_cnt), 128'(196));
    chk("t4_latency", 128'(lat_bad), 128'(0));
    chk("t4_data", 128'(data_bad), 128'(0));
    chk("t4_busy_end", 128'(o_busy), 128'(0));
    chk("t4_err", 128'(o_err), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
